// File: rtl/corelet_ctrl.sv
// Pass sequencer for one corelet: xmem fetch into L0/IFIFO, weight load or flush, execute,
// then OFIFO drain into pmem with SFU controls. Every output is a registered decode of the current state.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic [len_bw-1:0]  len,
    input  logic               relu_en,
    input  logic               acc_en,
    input  logic               ofifo_valid,
    output logic               os_or_ws,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic               ififo_wr,
    output logic               ififo_rd,
    output logic               kflush,
    output logic               execute,
    output logic               ofifo_rd,
    output logic               sfu_acc,
    output logic               sfu_relu,
    output logic               xmem_cen,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               pmem_wen,
    output logic [addr_bw-1:0] pmem_addr,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_FETCH = 3'd1;
    localparam logic [2:0] S_W_LOAD  = 3'd2;
    localparam logic [2:0] S_A_FETCH = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;
    localparam logic [2:0] S_DRAIN   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam logic [len_bw-1:0] COL_N = len_bw'(col);
    localparam logic [len_bw-1:0] ROW_N = len_bw'(row);

    logic [2:0]        r_state;
    logic [len_bw-1:0] r_cnt;
    logic [len_bw-1:0] r_popped;
    logic [len_bw-1:0] r_len;
    logic              r_mode, r_relu, r_acc;

    logic r_os_or_ws, r_l0_wr, r_l0_rd, r_ififo_wr, r_ififo_rd, r_kflush, r_execute;
    logic r_ofifo_rd, r_sfu_acc, r_sfu_relu, r_xmem_cen, r_pmem_wen, r_busy, r_done;
    logic [addr_bw-1:0] r_xmem_addr, r_pmem_addr;

    logic w_os_or_ws, w_l0_wr, w_l0_rd, w_ififo_wr, w_ififo_rd, w_kflush, w_execute;
    logic w_ofifo_rd, w_sfu_acc, w_sfu_relu, w_xmem_cen, w_pmem_wen, w_busy, w_done;
    logic [addr_bw-1:0] w_xmem_addr, w_pmem_addr, w_abase;
    logic [len_bw-1:0]  w_tgt;
    logic               w_pop;

    assign w_tgt   = r_mode ? ROW_N : r_len;
    assign w_abase = r_mode ? '0 : addr_bw'(col);
    assign w_pop   = (r_state == S_DRAIN) && ofifo_valid && (r_popped < w_tgt);

    always_comb begin
        w_os_or_ws  = (r_state != S_IDLE) && r_mode;
        w_busy      = (r_state != S_IDLE);
        w_l0_wr     = 1'b0;
        w_l0_rd     = 1'b0;
        w_ififo_wr  = 1'b0;
        w_ififo_rd  = 1'b0;
        w_kflush    = 1'b0;
        w_execute   = 1'b0;
        w_ofifo_rd  = 1'b0;
        w_sfu_acc   = 1'b0;
        w_sfu_relu  = 1'b0;
        w_xmem_cen  = 1'b1;
        w_xmem_addr = '0;
        w_pmem_wen  = 1'b1;
        w_pmem_addr = '0;
        w_done      = 1'b0;
        case (r_state)
            S_W_FETCH: begin
                // xmem data lands one cycle after the read, so the L0 write trails the enable
                w_xmem_cen = !(r_cnt < COL_N);
                if (r_cnt < COL_N) w_xmem_addr = addr_bw'(r_cnt);
                w_l0_wr    = (r_cnt != '0);
            end
            S_W_LOAD: begin
                w_kflush = 1'b1;
                w_l0_rd  = 1'b1;
            end
            S_A_FETCH: begin
                w_xmem_cen = !(r_cnt < r_len);
                if (r_cnt < r_len) w_xmem_addr = w_abase + addr_bw'(r_cnt);
                w_l0_wr    = (r_cnt != '0);
                w_ififo_wr = (r_cnt != '0) && r_mode;
            end
            S_EXEC: begin
                w_execute  = 1'b1;
                w_l0_rd    = 1'b1;
                w_ififo_rd = r_mode;
            end
            S_FLUSH: w_kflush = 1'b1;
            S_DRAIN: begin
                w_sfu_acc  = r_mode ? 1'b0 : r_acc;
                w_sfu_relu = r_mode ? 1'b1 : r_relu;
                if (w_pop) begin
                    w_ofifo_rd  = 1'b1;
                    w_pmem_wen  = 1'b0;
                    w_pmem_addr = addr_bw'(r_popped);
                end
            end
            S_DONE:  w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_popped <= '0;
            r_len    <= '0;
            r_mode   <= 1'b0;
            r_relu   <= 1'b0;
            r_acc    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (start) begin
                    r_mode   <= mode;
                    r_len    <= len;
                    r_relu   <= relu_en;
                    r_acc    <= acc_en;
                    r_cnt    <= '0;
                    r_popped <= '0;
                    r_state  <= (len == '0) ? S_DONE : (mode ? S_A_FETCH : S_W_FETCH);
                end
                S_W_FETCH: if (r_cnt == COL_N) begin
                    r_cnt <= '0; r_state <= S_W_LOAD;
                end else r_cnt <= r_cnt + 1'b1;
                S_W_LOAD: if (r_cnt == COL_N - 1'b1) begin
                    r_cnt <= '0; r_state <= S_A_FETCH;
                end else r_cnt <= r_cnt + 1'b1;
                S_A_FETCH: if (r_cnt == r_len) begin
                    r_cnt <= '0; r_state <= S_EXEC;
                end else r_cnt <= r_cnt + 1'b1;
                S_EXEC: if (r_cnt == r_len - 1'b1) begin
                    r_cnt <= '0; r_state <= r_mode ? S_FLUSH : S_DRAIN;
                end else r_cnt <= r_cnt + 1'b1;
                S_FLUSH: if (r_cnt == ROW_N - 1'b1) begin
                    r_cnt <= '0; r_state <= S_DRAIN;
                end else r_cnt <= r_cnt + 1'b1;
                S_DRAIN: begin
                    if (w_pop) r_popped <= r_popped + 1'b1;
                    if (r_popped == w_tgt) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_os_or_ws <= 1'b0; r_l0_wr <= 1'b0; r_l0_rd <= 1'b0; r_ififo_wr <= 1'b0;
            r_ififo_rd <= 1'b0; r_kflush <= 1'b0; r_execute <= 1'b0; r_ofifo_rd <= 1'b0;
            r_sfu_acc <= 1'b0; r_sfu_relu <= 1'b0; r_xmem_cen <= 1'b1; r_xmem_addr <= '0;
            r_pmem_wen <= 1'b1; r_pmem_addr <= '0; r_busy <= 1'b0; r_done <= 1'b0;
        end else begin
            r_os_or_ws <= w_os_or_ws; r_l0_wr <= w_l0_wr; r_l0_rd <= w_l0_rd; r_ififo_wr <= w_ififo_wr;
            r_ififo_rd <= w_ififo_rd; r_kflush <= w_kflush; r_execute <= w_execute; r_ofifo_rd <= w_ofifo_rd;
            r_sfu_acc <= w_sfu_acc; r_sfu_relu <= w_sfu_relu; r_xmem_cen <= w_xmem_cen; r_xmem_addr <= w_xmem_addr;
            r_pmem_wen <= w_pmem_wen; r_pmem_addr <= w_pmem_addr; r_busy <= w_busy; r_done <= w_done;
        end
    end

    assign os_or_ws  = r_os_or_ws;
    assign l0_wr     = r_l0_wr;
    assign l0_rd     = r_l0_rd;
    assign ififo_wr  = r_ififo_wr;
    assign ififo_rd  = r_ififo_rd;
    assign kflush    = r_kflush;
    assign execute   = r_execute;
    assign ofifo_rd  = r_ofifo_rd;
    assign sfu_acc   = r_sfu_acc;
    assign sfu_relu  = r_sfu_relu;
    assign xmem_cen  = r_xmem_cen;
    assign xmem_addr = r_xmem_addr;
    assign pmem_wen  = r_pmem_wen;
    assign pmem_addr = r_pmem_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: per-cycle strobe counting with hand-computed totals.
module tb_corelet_ctrl;

    logic        clk, reset, start, mode, relu_en, acc_en, ofifo_valid;
    logic [7:0]  len;
    logic        os_or_ws, l0_wr, l0_rd, ififo_wr, ififo_rd, kflush, execute, ofifo_rd;
    logic        sfu_acc, sfu_relu, xmem_cen, pmem_wen, busy, done;
    logic [10:0] xmem_addr, pmem_addr;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
        .relu_en(relu_en), .acc_en(acc_en), .ofifo_valid(ofifo_valid),
        .os_or_ws(os_or_ws), .l0_wr(l0_wr), .l0_rd(l0_rd), .ififo_wr(ififo_wr),
        .ififo_rd(ififo_rd), .kflush(kflush), .execute(execute), .ofifo_rd(ofifo_rd),
        .sfu_acc(sfu_acc), .sfu_relu(sfu_relu), .xmem_cen(xmem_cen), .xmem_addr(xmem_addr),
        .pmem_wen(pmem_wen), .pmem_addr(pmem_addr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_err = 0, n_chk = 0;
    int n_l0wr, n_l0rd, n_iwr, n_ird, n_kf, n_ex, n_ord, n_xcen, n_done, n_relu, n_acc, n_os;
    int bad_valid, bad_paddr, bad_xaddr, bad_lat;
    bit vtog = 0, prev_valid = 0, prev_cen_low = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_l0wr = 0; n_l0rd = 0; n_iwr = 0; n_ird = 0; n_kf = 0; n_ex = 0; n_ord = 0;
        n_xcen = 0; n_done = 0; n_relu = 0; n_acc = 0; n_os = 0;
        bad_valid = 0; bad_paddr = 0; bad_xaddr = 0; bad_lat = 0;
    endtask

    // Advance to the next falling edge, tally the outputs, then drive ofifo_valid for the next edge.
    task automatic tick();
        @(negedge clk);
        if (l0_wr) begin n_l0wr++; if (!prev_cen_low) bad_lat++; end
        if (l0_rd) n_l0rd++;
        if (ififo_wr) n_iwr++;
        if (ififo_rd) n_ird++;
        if (kflush) n_kf++;
        if (execute) n_ex++;
        if (done) n_done++;
        if (os_or_ws) n_os++;
        if (!xmem_cen) begin
            if (int'(xmem_addr) != n_xcen) bad_xaddr++;
            n_xcen++;
        end
        prev_cen_low = !xmem_cen;
        if (ofifo_rd) begin
            if (!prev_valid) bad_valid++;
            if (pmem_wen !== 1'b0 || int'(pmem_addr) != n_ord) bad_paddr++;
            if (sfu_relu) n_relu++;
            if (sfu_acc) n_acc++;
            n_ord++;
        end
        ofifo_valid = vtog ? ~ofifo_valid : 1'b1;
        prev_valid  = ofifo_valid;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && n_done == 0; i++) tick();
        chk("done_within_bound", int'(n_done != 0), 1);
        repeat (4) tick();
    endtask

    task automatic launch(input bit m, input int l, input bit relu, input bit acc);
        mode = m; len = 8'(l); relu_en = relu; acc_en = acc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_exec();
        for (int i = 0; i < 100 && !execute; i++) tick();
        chk("reached_exec", int'(execute), 1);
    endtask

    task automatic chk_ws4(input string p);
        chk({p, "_l0_wr"}, n_l0wr, 12);
        chk({p, "_l0_rd"}, n_l0rd, 12);
        chk({p, "_kflush"}, n_kf, 8);
        chk({p, "_execute"}, n_ex, 4);
        chk({p, "_ofifo_rd"}, n_ord, 4);
        chk({p, "_done"}, n_done, 1);
        chk({p, "_xmem_rd"}, n_xcen, 12);
        chk({p, "_pmem_addr"}, bad_paddr, 0);
        chk({p, "_xmem_addr"}, bad_xaddr, 0);
        chk({p, "_pop_wo_valid"}, bad_valid, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = 1'b0; len = 8'd0;
        relu_en = 1'b0; acc_en = 1'b0; ofifo_valid = 1'b1;
        clr();
        tick(); tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xmem_cen", int'(xmem_cen), 1);
        chk("rst_pmem_wen", int'(pmem_wen), 1);
        chk("rst_os_or_ws", int'(os_or_ws), 0);
        chk("rst_xmem_addr", int'(xmem_addr), 0);
        reset = 1'b0;
        tick();

        // WS len=4, relu on, acc off
        clr();
        launch(1'b0, 4, 1'b1, 1'b0);
        wait_done(200);
        chk_ws4("ws");
        chk("ws_ififo_wr", n_iwr, 0);
        chk("ws_ififo_rd", n_ird, 0);
        chk("ws_relu", n_relu, 4);
        chk("ws_acc", n_acc, 0);
        chk("ws_l0_latency", bad_lat, 0);
        chk("ws_idle_busy", int'(busy), 0);

        // OS len=3
        clr();
        launch(1'b1, 3, 1'b0, 1'b1);
        wait_done(200);
        chk("os_l0_wr", n_l0wr, 3);
        chk("os_ififo_wr", n_iwr, 3);
        chk("os_execute", n_ex, 3);
        chk("os_ififo_rd", n_ird, 3);
        chk("os_kflush", n_kf, 8);
        chk("os_ofifo_rd", n_ord, 8);
        chk("os_pmem_addr", bad_paddr, 0);
        chk("os_relu", n_relu, 8);
        chk("os_acc", n_acc, 0);
        chk("os_xmem_rd", n_xcen, 3);
        chk("os_xmem_addr", bad_xaddr, 0);
        chk("os_mode_seen", int'(n_os > 0), 1);

        // WS len=4 with ofifo_valid toggling, acc on
        clr();
        vtog = 1'b1;
        launch(1'b0, 4, 1'b0, 1'b1);
        wait_done(300);
        vtog = 1'b0;
        chk_ws4("tog");
        chk("tog_acc", n_acc, 4);
        chk("tog_relu", n_relu, 0);

        // start pulsed during EXEC is ignored
        clr();
        launch(1'b0, 4, 1'b0, 1'b0);
        wait_exec();
        start = 1'b1; tick(); start = 1'b0;
        wait_done(200);
        repeat (20) tick();
        chk_ws4("restart");

        // reset mid-EXEC abandons the pass
        clr();
        launch(1'b0, 4, 1'b0, 1'b0);
        wait_exec();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_execute", int'(execute), 0);
        chk("mid_rst_l0_rd", int'(l0_rd), 0);
        chk("mid_rst_xmem_cen", int'(xmem_cen), 1);
        tick();
        reset = 1'b0;
        clr();
        repeat (30) tick();
        chk("mid_rst_no_done", n_done, 0);
        chk("mid_rst_idle", int'(busy), 0);
        clr();
        launch(1'b0, 4, 1'b0, 1'b0);
        wait_done(200);
        chk_ws4("post_rst");

        // len=0 goes straight to DONE
        clr();
        launch(1'b0, 0, 1'b0, 1'b0);
        chk("len0_done_c1", int'(done), 0);
        tick();
        chk("len0_done_c2", int'(done), 1);
        tick();
        chk("len0_done_c3", int'(done), 0);
        repeat (5) tick();
        chk("len0_done_cnt", n_done, 1);
        chk("len0_xmem_rd", n_xcen, 0);
        chk("len0_strobes", n_l0wr + n_l0rd + n_kf + n_ex + n_ord, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
